// File: rtl/lfsr_pattern_gen_if.sv
// Run-control and pattern bus between the BIST controller (master) and the
// LFSR pattern generator (slave).
interface lfsr_pattern_gen_if #(
    parameter int BITS  = 8,
    parameter int CNT_W = 16
);
    logic             load;
    logic [BITS-1:0]  poly_in;
    logic [BITS-1:0]  seed_in;
    logic [CNT_W-1:0] n_patterns;
    logic             start;
    logic             step_en;
    logic             stop;

    logic [BITS-1:0]  register;
    logic             valid;
    logic             busy;
    logic             done;
    logic             END;
    logic             seed_err;
    logic [CNT_W-1:0] pat_cnt;

    modport master (
        output load, poly_in, seed_in, n_patterns, start, step_en, stop,
        input  register, valid, busy, done, END, seed_err, pat_cnt
    );

    modport slave (
        input  load, poly_in, seed_in, n_patterns, start, step_en, stop,
        output register, valid, busy, done, END, seed_err, pat_cnt
    );
endinterface

// File: rtl/lfsr_pattern_gen.sv
// LBIST pattern generator: Fibonacci (MODE 0) or Galois (MODE 1) LFSR with run-control FSM.
// Optional LFSR_ZERO_STATE_EN adds the de Bruijn all-zero state in MODE 0.
module lfsr_pattern_gen #(
    parameter int              BITS  = 8,
    parameter int              MODE  = 0,
    parameter logic [BITS-1:0] POLY  = BITS'(8'b0001_1101),
    parameter logic [BITS-1:0] SEED  = BITS'(8'b0000_0001),
    parameter int              CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_pattern_gen_if.slave   bus
);

    if (BITS < 3 || BITS > 32) begin : g_bits_chk
        $error("lfsr_pattern_gen: BITS must be within 3..32");
    end
    if (POLY[0] != 1'b1) begin : g_poly_chk
        $error("lfsr_pattern_gen: POLY bit 0 must be set");
    end

`ifdef LFSR_ZERO_STATE_EN
    localparam bit ZERO_OK = (MODE == 0);
`else
    localparam bit ZERO_OK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [BITS-1:0]  poly_reg;
    logic [BITS-1:0]  seed_reg;
    logic [BITS-1:0]  register_q;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] pat_cnt_q;
    logic             seed_err_q;

    logic             do_load;
    logic             do_reject;
    logic             do_start;
    logic             do_consume;
    logic             seed_ok;
    logic             run_finished;
    logic [BITS-1:0]  lfsr_next;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] pat_cnt_sat;

    // One LFSR step; the zero-state tweak forces 0..01 -> 0..00 -> 10..0.
    function automatic logic [BITS-1:0] lfsr_advance(input logic [BITS-1:0] cur,
                                                     input logic [BITS-1:0] taps);
        logic fb;
        if (MODE == 0) begin
            fb = ^(cur & taps);
`ifdef LFSR_ZERO_STATE_EN
            fb = fb ^ (cur[BITS-1:1] == '0);
`endif
            return {fb, cur[BITS-1:1]};
        end
        return (cur >> 1) ^ (cur[0] ? taps : '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W:0] sum,
                                                   input logic [CNT_W-1:0] cur);
        return sum[CNT_W] ? cur : sum[CNT_W-1:0];
    endfunction

    assign seed_ok     = (bus.seed_in != '0) || ZERO_OK;
    assign lfsr_next   = lfsr_advance(register_q, poly_reg);
    assign cnt_inc     = {1'b0, pat_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign pat_cnt_sat = sat_count(cnt_inc, pat_cnt_q);

    // n_reg == 0 means "stop on first return to the seed".
    assign run_finished = (n_reg != '0) ? (cnt_inc == {1'b0, n_reg})
                                        : (lfsr_next == seed_reg);

    always_comb begin
        state_d    = state_q;
        do_load    = 1'b0;
        do_reject  = 1'b0;
        do_start   = 1'b0;
        do_consume = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    if (seed_ok) begin
                        do_load = 1'b1;
                    end else begin
                        do_reject = 1'b1;
                    end
                end else if (bus.start) begin
                    do_start = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.step_en) begin
                    do_consume = 1'b1;
                    if (run_finished) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poly_reg   <= POLY;
            seed_reg   <= SEED;
            register_q <= SEED;
            n_reg      <= '0;
            pat_cnt_q  <= '0;
            seed_err_q <= 1'b0;
        end else begin
            seed_err_q <= do_reject;
            if (do_load) begin
                poly_reg   <= bus.poly_in;
                seed_reg   <= bus.seed_in;
                register_q <= bus.seed_in;
            end
            if (do_start) begin
                n_reg      <= bus.n_patterns;
                pat_cnt_q  <= '0;
                register_q <= seed_reg;
            end
            if (do_consume) begin
                register_q <= lfsr_next;
                pat_cnt_q  <= pat_cnt_sat;
            end
        end
    end

    assign bus.register = register_q;
    assign bus.valid    = (state_q == S_RUN);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.END      = (register_q == seed_reg);
    assign bus.seed_err = seed_err_q;
    assign bus.pat_cnt  = pat_cnt_q;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Scoreboard bench for lfsr_pattern_gen: two 4-bit instances (Fibonacci and Galois).
module tb_lfsr_pattern_gen;
    localparam int BITS  = 4;
    localparam int CNT_W = 8;

    localparam logic [3:0] FIB [15] = '{4'b0001, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                        4'b0111, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                                        4'b0110, 4'b0011, 4'b1001, 4'b0100, 4'b0010};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_pattern_gen_if #(.BITS(BITS), .CNT_W(CNT_W)) b0 ();
    lfsr_pattern_gen_if #(.BITS(BITS), .CNT_W(CNT_W)) b1 ();

    lfsr_pattern_gen #(.BITS(4), .MODE(0), .POLY(4'b1001), .SEED(4'b0001), .CNT_W(CNT_W))
        dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    lfsr_pattern_gen #(.BITS(4), .MODE(1), .POLY(4'b0011), .SEED(4'b1000), .CNT_W(CNT_W))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp0 [$];
    logic [3:0] exp1 [$];
    logic [3:0] seq0 [$];
    logic [3:0] pat0;
    logic [3:0] pat1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted pattern must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && b0.valid && b0.step_en && !b0.stop) begin
            if (exp0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dut0_pattern: got %b, expected no pattern", b0.register);
            end else begin
                pat0 = exp0.pop_front();
                check("dut0_pattern", 32'(b0.register), 32'(pat0));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b1.valid && b1.step_en && !b1.stop) begin
            if (exp1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dut1_pattern: got %b, expected no pattern", b1.register);
            end else begin
                pat1 = exp1.pop_front();
                check("dut1_pattern", 32'(b1.register), 32'(pat1));
            end
        end
    end

    task automatic push0(input int n);
        for (int i = 0; i < n; i++) exp0.push_back(seq0[i]);
    endtask

    task automatic load0(input logic [3:0] p, input logic [3:0] s);
        b0.load    = 1'b1;
        b0.poly_in = p;
        b0.seed_in = s;
        tick();
        b0.load    = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cycles++;
            if ((sel ? b1.done : b0.done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_full0(input string tag);
        int  cyc;
        bit  seen;
        int  len;
        len = seq0.size();
        push0(len);
        b0.n_patterns = '0;
        b0.step_en    = 1'b1;
        b0.start      = 1'b1;
        tick();
        b0.start      = 1'b0;
        wait_done(1'b0, cyc, seen);
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_done_latency"}, cyc, len);
        check({tag, "_pat_cnt"}, 32'(b0.pat_cnt), len);
        check({tag, "_end_reg"}, 32'(b0.register), 4'b0001);
        check({tag, "_END"}, 32'(b0.END), 1);
        b0.step_en = 1'b0;
        tick();
        check({tag, "_done_cleared"}, 32'(b0.done), 0);
        check({tag, "_busy_low"}, 32'(b0.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen;

        seq0.push_back(FIB[0]);
`ifdef LFSR_ZERO_STATE_EN
        seq0.push_back(4'b0000);
`endif
        for (int i = 1; i < 15; i++) seq0.push_back(FIB[i]);

        b0.load = 0; b0.poly_in = '0; b0.seed_in = '0; b0.n_patterns = '0;
        b0.start = 0; b0.step_en = 0; b0.stop = 0;
        b1.load = 0; b1.poly_in = '0; b1.seed_in = '0; b1.n_patterns = '0;
        b1.start = 0; b1.step_en = 0; b1.stop = 0;

        rst = 1'b1;
        tick();
        tick();
        check("rst_register0", 32'(b0.register), 4'b0001);
        check("rst_register1", 32'(b1.register), 4'b1000);
        check("rst_valid", 32'(b0.valid), 0);
        check("rst_busy", 32'(b0.busy), 0);
        check("rst_done", 32'(b0.done), 0);
        check("rst_seed_err", 32'(b0.seed_err), 0);
        check("rst_pat_cnt", 32'(b0.pat_cnt), 0);
        check("rst_END0", 32'(b0.END), 1);
        check("rst_END1", 32'(b1.END), 1);
        rst = 1'b0;
        tick();

        // Full period, Fibonacci
        load0(4'b1001, 4'b0001);
        check("load_seed_err", 32'(b0.seed_err), 0);
        run_full0("full");

        // Galois, n=5, after loading over the reset poly/seed
        b1.load = 1'b1; b1.poly_in = 4'b1001; b1.seed_in = 4'b0001;
        tick();
        b1.load = 1'b0;
        check("g_load_reg", 32'(b1.register), 4'b0001);
        exp1.push_back(4'b0001); exp1.push_back(4'b1001); exp1.push_back(4'b1101);
        exp1.push_back(4'b1111); exp1.push_back(4'b1110);
        b1.n_patterns = 8'd5;
        b1.step_en    = 1'b1;
        b1.start      = 1'b1;
        tick();
        b1.start      = 1'b0;
        check("g_valid", 32'(b1.valid), 1);
        wait_done(1'b1, cyc, seen);
        check("g_done_seen", 32'(seen), 1);
        check("g_done_latency", cyc, 5);
        check("g_pat_cnt", 32'(b1.pat_cnt), 5);
        b1.step_en = 1'b0;
        tick();
        check("g_idle_busy", 32'(b1.busy), 0);
        check("g_idle_END", 32'(b1.END), 0);
        check("g_idle_reg", 32'(b1.register), 4'b0111);

        // n=4 with step_en toggling
        push0(4);
        b0.n_patterns = 8'd4;
        b0.start      = 1'b1;
        tick();
        b0.start      = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            b0.step_en = (k % 2 == 0);
            tick();
            cyc++;
            if (b0.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("tog_done_seen", 32'(seen), 1);
        check("tog_done_latency", cyc, 7);
        check("tog_pat_cnt", 32'(b0.pat_cnt), 4);
        b0.step_en = 1'b0;
        tick();

        // stop with a coincident consume at the 3rd pattern
        push0(2);
        b0.n_patterns = 8'd10;
        b0.step_en    = 1'b1;
        b0.start      = 1'b1;
        tick();
        b0.start      = 1'b0;
        tick();
        tick();
        b0.stop = 1'b1;
        tick();
        b0.stop    = 1'b0;
        b0.step_en = 1'b0;
        check("stop_busy", 32'(b0.busy), 0);
        check("stop_valid", 32'(b0.valid), 0);
        check("stop_done", 32'(b0.done), 0);
        check("stop_reg_held", 32'(b0.register), 32'(seq0[2]));
        check("stop_pat_cnt", 32'(b0.pat_cnt), 2);
        tick();
        check("stop_no_done", 32'(b0.done), 0);

        // zero seed
        load0(4'b1001, 4'b0000);
`ifdef LFSR_ZERO_STATE_EN
        check("zero_seed_err", 32'(b0.seed_err), 0);
        check("zero_seed_reg", 32'(b0.register), 4'b0000);
        load0(4'b1001, 4'b0001);
`else
        check("zero_seed_err", 32'(b0.seed_err), 1);
        check("zero_seed_reg", 32'(b0.register), 32'(seq0[2]));
        tick();
        check("zero_seed_err_pulse", 32'(b0.seed_err), 0);
`endif

        // load and start together: load wins
        b0.load = 1'b1; b0.poly_in = 4'b1001; b0.seed_in = 4'b0001; b0.start = 1'b1;
        tick();
        b0.load = 1'b0; b0.start = 1'b0;
        check("ldst_busy", 32'(b0.busy), 0);
        check("ldst_reg", 32'(b0.register), 4'b0001);

        // rst mid-run after loading poly 0011 / seed 0110
        load0(4'b0011, 4'b0110);
        exp0.push_back(4'b0110);
        exp0.push_back(4'b1011);
        b0.n_patterns = '0;
        b0.step_en    = 1'b1;
        b0.start      = 1'b1;
        tick();
        b0.start      = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mrst_reg", 32'(b0.register), 4'b0001);
        check("mrst_busy", 32'(b0.busy), 0);
        check("mrst_valid", 32'(b0.valid), 0);
        check("mrst_pat_cnt", 32'(b0.pat_cnt), 0);
        check("mrst_END", 32'(b0.END), 1);
        b0.step_en = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        run_full0("post_rst");

        repeat (3) tick();
        check("queue0_drained", exp0.size(), 0);
        check("queue1_drained", exp1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
